// File: rtl/picosoc_regs_pkg.sv
// Shared types and defaults for the picosoc two-read/one-write register file.
package picosoc_regs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // INIT clears every entry after reset, RUN serves the core.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Source of a read port's output: forced zero, RAM bank, or forwarded write data.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_BYP  = 2'd2
  } rsel_e;

endpackage

// File: rtl/picosoc_regs_bank.sv
// Simple dual-port RAM bank: one synchronous write port, one synchronous
// read-first read port. No reset so it maps onto block RAM.
module picosoc_regs_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Write and read on the same edge; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/picosoc_regs_dp.sv
// picosoc register file: two read ports, one write port, one RAM bank per
// read port. Clears itself after reset, optional hardwired x0.
// Optional same-cycle write-to-read forwarding: PICOSOC_REGS_BYPASS_EN.
module picosoc_regs_dp
  import picosoc_regs_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_e          state_q;
  logic [ADDR_W:0] cnt_q;
  logic            ready_q;
  logic            rvalid_q;
  rsel_e           sel1_q, sel2_q;
  rsel_e           sel1_d, sel2_d;

  logic              run, wr_drop, wr_ok, rd_ok;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] ram1, ram2;
  logic              byp1, byp2;
  logic              rd_zero1, rd_zero2;

  assign run      = (state_q == RUN);
  assign wr_drop  = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok    = run && wen && !wr_drop;
  assign rd_ok    = run && ren && !reset;
  assign rd_zero1 = (ZERO_REG != 0) && (raddr1 == '0);
  assign rd_zero2 = (ZERO_REG != 0) && (raddr2 == '0);

  // Sweep owns the write port in INIT; nothing is written on a reset edge.
  assign bank_we    = !reset && (run ? wr_ok : 1'b1);
  assign bank_waddr = run ? waddr : cnt_q[ADDR_W-1:0];
  assign bank_wdata = run ? wdata : '0;

`ifdef PICOSOC_REGS_BYPASS_EN
  assign byp1 = wr_ok && (waddr == raddr1);
  assign byp2 = wr_ok && (waddr == raddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Output source chosen at read time; zero override beats forwarding.
  always_comb begin
    sel1_d = rd_zero1 ? SEL_ZERO : (byp1 ? SEL_BYP : SEL_RAM);
    sel2_d = rd_zero2 ? SEL_ZERO : (byp2 ? SEL_BYP : SEL_RAM);
  end

  picosoc_regs_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (rd_ok),
    .raddr (raddr1),
    .rdata (ram1)
  );

  picosoc_regs_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank2 (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (rd_ok),
    .raddr (raddr2),
    .rdata (ram2)
  );

  // FSM: clear sweep then run; tracks read-port source and rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      sel1_q   <= SEL_ZERO;
      sel2_q   <= SEL_ZERO;
    end else begin
      case (state_q)
        INIT: begin
          rvalid_q <= 1'b0;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          rvalid_q <= ren;
          if (ren) begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef PICOSOC_REGS_BYPASS_EN
  logic [DATA_W-1:0] byp1_q, byp2_q;

  // Capture forwarded write data alongside the read that needs it.
  always_ff @(posedge clk) begin
    if (rd_ok && byp1) byp1_q <= wdata;
    if (rd_ok && byp2) byp2_q <= wdata;
  end
`endif

  // Output mux over registered sources only, so rdata stays glitch-free.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    case (sel1_q)
      SEL_RAM: rdata1 = ram1;
`ifdef PICOSOC_REGS_BYPASS_EN
      SEL_BYP: rdata1 = byp1_q;
`endif
      default: rdata1 = '0;
    endcase
    case (sel2_q)
      SEL_RAM: rdata2 = ram2;
`ifdef PICOSOC_REGS_BYPASS_EN
      SEL_BYP: rdata2 = byp2_q;
`endif
      default: rdata2 = '0;
    endcase
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_picosoc_regs_dp.sv
// Scoreboard bench for picosoc_regs_dp (ZERO_REG = 1, 32 x 32).
module tb_picosoc_regs_dp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic [AW-1:0] raddr1 = '0, raddr2 = '0;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid;

  always #5 clk = ~clk;

  picosoc_regs_dp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid)
  );

  int errs = 0;
  int chks = 0;

  logic [DW-1:0] mem [0:DEPTH-1];
  int            mcnt = 0;
  bit            mready = 0;
  logic [DW-1:0] last1 = '0, last2 = '0;
  logic [2*DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra, input bit w,
                                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] v;
    if (ra == '0) v = '0;
    else v = mem[ra];
`ifdef PICOSOC_REGS_BYPASS_EN
    if (w && wa == ra && wa != '0) v = wd;
`endif
    return v;
  endfunction

  // One clock: drive, predict, advance, check.
  task automatic step(input bit rst, input bit w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input bit r,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bit exp_v;
    logic [2*DW-1:0] e;
    reset = rst; wen = w; waddr = wa; wdata = wd; ren = r; raddr1 = a1; raddr2 = a2;
    exp_v = 0;
    if (rst) begin
      mcnt = 0; mready = 0; last1 = '0; last2 = '0;
      sb.delete();
    end else if (!mready) begin
      mem[mcnt] = '0;
      mcnt++;
    end else begin
      if (r) begin
        sb.push_back({exp_rd(a1, w, wa, wd), exp_rd(a2, w, wa, wd)});
        exp_v = 1;
      end
      if (w && wa != '0) mem[wa] = wd;
    end
    @(posedge clk); #1;
    if (!rst && !mready && mcnt == DEPTH) mready = 1;
    chk("ready", {63'd0, ready}, {63'd0, mready});
    chk("rvalid", {63'd0, rvalid}, {63'd0, exp_v});
    if (rvalid && sb.size() > 0) begin
      e = sb.pop_front();
      last1 = e[2*DW-1:DW];
      last2 = e[DW-1:0];
    end
    chk("rdata1", {32'd0, rdata1}, {32'd0, last1});
    chk("rdata2", {32'd0, rdata2}, {32'd0, last2});
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(0, 0, '0, '0, 1, a1, a2);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    step(0, 1, wa, wd, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hBAD0_0000 + i;
    #1;
    step(1, 0, '0, '0, 0, '0, '0);
    step(1, 1, 5'd3, 32'h1111, 1, 5'd3, 5'd4);

    // Sweep with reads and writes requested throughout: all must be ignored.
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 5'(i), $urandom, 1, 5'($urandom), 5'($urandom));
    // Read every entry: all cleared.
    for (int i = 0; i < DEPTH; i++) rd(5'(i), 5'(DEPTH - 1 - i));
    step(0, 0, '0, '0, 0, '0, '0);

    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    wr(5'd0, 32'h12345678);
    rd(5'd0, 5'd0);

    // Same-cycle write/read of x7.
    wr(5'd7, 32'h1);
    step(0, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 5'd7);
    rd(5'd7, 5'd7);
    step(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 5'd7);

    // Reset pulse in RUN with read and write pending.
    step(1, 1, 5'd5, 32'hCAFE, 1, 5'd5, 5'd5);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 5'd5, $urandom, 1, 5'd5, 5'd7);
    rd(5'd5, 5'd7);

    // Random traffic, with holds between reads.
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
